// File: rtl/ccr_exmem_stage.sv
// ccr_exmem_stage
// EX/MEM pipeline register that sits directly behind the 16-bit ALU.
// It owns the architectural carry/zero condition-code register, which it
// feeds back to the ALU, and it cancels the register write of conditional
// ADD/NAND instructions whose condition is false ("squash").
//
// Optional feature: define CCR_SQUASH_CNT_EN to build a saturating counter
// of squashed conditionals on squash_count. Without the macro,
// squash_count is tied to zero and no counter logic is built.
module ccr_exmem_stage #(
  parameter int CCR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ex_valid,
  input  logic [2:0]           ex_alu_control,
  input  logic [15:0]          ex_out_alu,
  input  logic                 ex_carry_out,
  input  logic                 ex_zero_out,
  input  logic                 ex_ccr_enable,
  input  logic [2:0]           ex_rd,
  input  logic                 ex_reg_write,
  input  logic                 mem_stall,
  input  logic                 flush,
  output logic                 ex_ready,
  output logic                 carry_flag,
  output logic                 zero_flag,
  output logic                 mem_valid,
  output logic [15:0]          mem_result,
  output logic [2:0]           mem_rd,
  output logic                 mem_reg_write,
  output logic                 mem_squashed,
  output logic [CCR_CNT_W-1:0] squash_count
);

  // Opcode encodings understood by this stage
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_ADC   = 3'b001;
  localparam logic [2:0] OP_ADZ   = 3'b010;
  localparam logic [2:0] OP_ADL   = 3'b011;
  localparam logic [2:0] OP_NDU   = 3'b100;
  localparam logic [2:0] OP_NDC   = 3'b101;
  localparam logic [2:0] OP_NDZ   = 3'b110;
  localparam logic [2:0] OP_ADX   = 3'b111;

  logic is_add_class;
  logic is_nand_class;
  logic is_carry_cond;
  logic is_zero_cond;
  logic sq;
  logic adv;
  logic flag_write;

  // The ALU may only advance into MEM when MEM is not being held
  assign ex_ready = !mem_stall;

  // Decode the opcode into classes and work out advance / squash
  always_comb begin
    is_add_class  = 1'b0;
    is_nand_class = 1'b0;
    is_carry_cond = 1'b0;
    is_zero_cond  = 1'b0;

    case (ex_alu_control)
      OP_ADD, OP_ADL, OP_ADX: is_add_class = 1'b1;
      OP_ADC: begin
        is_add_class  = 1'b1;
        is_carry_cond = 1'b1;
      end
      OP_ADZ: begin
        is_add_class = 1'b1;
        is_zero_cond = 1'b1;
      end
      OP_NDU: is_nand_class = 1'b1;
      OP_NDC: begin
        is_nand_class = 1'b1;
        is_carry_cond = 1'b1;
      end
      OP_NDZ: begin
        is_nand_class = 1'b1;
        is_zero_cond  = 1'b1;
      end
      default: begin
        is_add_class  = 1'b0;
        is_nand_class = 1'b0;
      end
    endcase

    // The condition is judged against our own architectural flags; the
    // ALU's enable says nothing about whether the condition held.
    sq = (is_carry_cond & !carry_flag) | (is_zero_cond & !zero_flag);

    adv = ex_valid & !flush & !mem_stall;

    flag_write = adv & !sq & ex_ccr_enable;
  end

  // EX/MEM pipeline register: load on advance, insert a bubble when not
  // stalled and nothing advances, hold everything while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid     <= 1'b0;
      mem_result    <= 16'h0000;
      mem_rd        <= 3'b000;
      mem_reg_write <= 1'b0;
      mem_squashed  <= 1'b0;
    end else if (!mem_stall) begin
      if (adv) begin
        mem_valid     <= 1'b1;
        mem_result    <= ex_out_alu;
        mem_rd        <= ex_rd;
        mem_reg_write <= ex_reg_write & !sq;
        mem_squashed  <= sq;
      end else begin
        mem_valid     <= 1'b0;
        mem_reg_write <= 1'b0;
        mem_squashed  <= 1'b0;
      end
    end
  end

  // Condition-code register: Z follows every flag-writing instruction,
  // C only follows the ADD class (NAND cannot produce a carry)
  always_ff @(posedge clk) begin
    if (reset) begin
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else if (flag_write) begin
      zero_flag <= ex_zero_out;
      if (is_add_class) begin
        carry_flag <= ex_carry_out;
      end
    end
  end

`ifdef CCR_SQUASH_CNT_EN
  localparam logic [CCR_CNT_W-1:0] CNT_MAX = {CCR_CNT_W{1'b1}};
  localparam logic [CCR_CNT_W-1:0] CNT_ONE = {{(CCR_CNT_W-1){1'b0}}, 1'b1};

  // Saturating count of squashed conditionals; only reset clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      squash_count <= '0;
    end else if (adv && sq && (squash_count != CNT_MAX)) begin
      squash_count <= squash_count + CNT_ONE;
    end
  end
`else
  assign squash_count = '0;
`endif

  // is_nand_class is decoded for completeness of the class table; the
  // carry rule only needs the ADD side of it
  logic unused_nand;
  assign unused_nand = is_nand_class;

endmodule

// File: tb/tb_ccr_exmem_stage.sv
// tb_ccr_exmem_stage
// Directed bench for ccr_exmem_stage. A reference model computes the
// expected MEM/flag state for each driven cycle and pushes it onto a
// scoreboard queue; after the clock edge the entry is popped and compared.
// Honours CCR_SQUASH_CNT_EN the same way the design does.
module tb_ccr_exmem_stage;

  localparam int CNT_W = 2;

  logic             clk;
  logic             reset;
  logic             ex_valid;
  logic [2:0]       ex_alu_control;
  logic [15:0]      ex_out_alu;
  logic             ex_carry_out;
  logic             ex_zero_out;
  logic             ex_ccr_enable;
  logic [2:0]       ex_rd;
  logic             ex_reg_write;
  logic             mem_stall;
  logic             flush;
  logic             ex_ready;
  logic             carry_flag;
  logic             zero_flag;
  logic             mem_valid;
  logic [15:0]      mem_result;
  logic [2:0]       mem_rd;
  logic             mem_reg_write;
  logic             mem_squashed;
  logic [CNT_W-1:0] squash_count;

  typedef struct packed {
    logic             valid;
    logic [15:0]      result;
    logic [2:0]       rd;
    logic             reg_write;
    logic             squashed;
    logic             c;
    logic             z;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t scoreboard[$];

  // Reference model state
  logic             m_valid;
  logic [15:0]      m_result;
  logic [2:0]       m_rd;
  logic             m_rw;
  logic             m_sq;
  logic             m_c;
  logic             m_z;
  logic [CNT_W-1:0] m_cnt;

  int total_checks;
  int failed_checks;

  ccr_exmem_stage #(.CCR_CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_valid       (ex_valid),
    .ex_alu_control (ex_alu_control),
    .ex_out_alu     (ex_out_alu),
    .ex_carry_out   (ex_carry_out),
    .ex_zero_out    (ex_zero_out),
    .ex_ccr_enable  (ex_ccr_enable),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .mem_stall      (mem_stall),
    .flush          (flush),
    .ex_ready       (ex_ready),
    .carry_flag     (carry_flag),
    .zero_flag      (zero_flag),
    .mem_valid      (mem_valid),
    .mem_result     (mem_result),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_squashed   (mem_squashed),
    .squash_count   (squash_count)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and on mismatch count and report it
  task automatic check1(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total_checks++;
    assert (obs === exp_v) else begin
      failed_checks++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs, advance the model and push its prediction
  task automatic applyStimulus(
    input logic        rst,
    input logic        valid,
    input logic [2:0]  op,
    input logic [15:0] res,
    input logic        c,
    input logic        z,
    input logic        en,
    input logic [2:0]  rd,
    input logic        rw,
    input logic        stall,
    input logic        fl
  );
    logic cc, zc, sq, add_cls, adv;
    exp_t e;
    reset          = rst;
    ex_valid       = valid;
    ex_alu_control = op;
    ex_out_alu     = res;
    ex_carry_out   = c;
    ex_zero_out    = z;
    ex_ccr_enable  = en;
    ex_rd          = rd;
    ex_reg_write   = rw;
    mem_stall      = stall;
    flush          = fl;
    #1;
    check1("ex_ready", {15'd0, ex_ready}, {15'd0, !stall});

    cc      = (op == 3'b001) || (op == 3'b101);
    zc      = (op == 3'b010) || (op == 3'b110);
    add_cls = (op[2] == 1'b0) || (op == 3'b111);
    sq      = (cc && !m_c) || (zc && !m_z);
    adv     = valid && !fl && !stall;

    if (rst) begin
      m_valid = 0; m_result = 0; m_rd = 0; m_rw = 0; m_sq = 0;
      m_c = 0; m_z = 0; m_cnt = 0;
    end else if (!stall) begin
      if (adv) begin
`ifdef CCR_SQUASH_CNT_EN
        if (sq && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
`endif
        m_valid  = 1;
        m_result = res;
        m_rd     = rd;
        m_rw     = rw && !sq;
        m_sq     = sq;
        if (!sq && en) begin
          m_z = z;
          if (add_cls) m_c = c;
        end
      end else begin
        m_valid = 0; m_rw = 0; m_sq = 0;
      end
    end

    e.valid     = m_valid;
    e.result    = m_result;
    e.rd        = m_rd;
    e.reg_write = m_rw;
    e.squashed  = m_sq;
    e.c         = m_c;
    e.z         = m_z;
    e.cnt       = m_cnt;
    scoreboard.push_back(e);
  endtask

  // Clock the DUT, then pop the prediction and compare every output
  task automatic checkOutput(input string step);
    exp_t e;
    @(posedge clk);
    #1;
    total_checks++;
    assert (scoreboard.size() != 0) else begin
      failed_checks++;
      $error("[TB] FAIL %s scoreboard observed=empty expected=entry", step);
    end
    if (scoreboard.size() != 0) begin
      e = scoreboard.pop_front();
      check1({step, ".mem_valid"},     {15'd0, mem_valid},     {15'd0, e.valid});
      check1({step, ".mem_result"},    mem_result,             e.result);
      check1({step, ".mem_rd"},        {13'd0, mem_rd},        {13'd0, e.rd});
      check1({step, ".mem_reg_write"}, {15'd0, mem_reg_write}, {15'd0, e.reg_write});
      check1({step, ".mem_squashed"},  {15'd0, mem_squashed},  {15'd0, e.squashed});
      check1({step, ".carry_flag"},    {15'd0, carry_flag},    {15'd0, e.c});
      check1({step, ".zero_flag"},     {15'd0, zero_flag},     {15'd0, e.z});
      check1({step, ".squash_count"},  {14'd0, squash_count},  {14'd0, e.cnt});
    end
  endtask

  // Directed sequence
  initial begin
    total_checks  = 0;
    failed_checks = 0;
    m_valid = 0; m_result = 0; m_rd = 0; m_rw = 0; m_sq = 0;
    m_c = 0; m_z = 0; m_cnt = 0;
    reset = 1; ex_valid = 0; ex_alu_control = 0; ex_out_alu = 0;
    ex_carry_out = 0; ex_zero_out = 0; ex_ccr_enable = 0; ex_rd = 0;
    ex_reg_write = 0; mem_stall = 0; flush = 0;
    @(posedge clk);
    #1;

    // Reset state
    applyStimulus(1, 0, 3'b000, 16'h0000, 0, 0, 0, 3'd0, 0, 0, 0); checkOutput("reset");
    // ADD setting C=1, Z=1
    applyStimulus(0, 1, 3'b000, 16'h0000, 1, 1, 1, 3'd1, 1, 0, 0); checkOutput("add_c1z1");
    // ADD clearing both flags
    applyStimulus(0, 1, 3'b000, 16'h1234, 0, 0, 1, 3'd2, 1, 0, 0); checkOutput("add_c0z0");
    // Carry-conditional with C=0: squashed
    applyStimulus(0, 1, 3'b001, 16'hBEEF, 1, 1, 1, 3'd5, 1, 0, 0); checkOutput("adc_sq");
    // ADD setting C=1, Z=0
    applyStimulus(0, 1, 3'b000, 16'h00FF, 1, 0, 1, 3'd3, 1, 0, 0); checkOutput("add_c1z0");
    // Carry-conditional with C=1: executes
    applyStimulus(0, 1, 3'b001, 16'hCAFE, 0, 0, 1, 3'd5, 1, 0, 0); checkOutput("adc_ok");
    // Restore C=1, Z=0 then NAND: Z updates, C stays
    applyStimulus(0, 1, 3'b011, 16'h0101, 1, 0, 1, 3'd4, 1, 0, 0); checkOutput("adl_c1z0");
    applyStimulus(0, 1, 3'b100, 16'h0000, 0, 1, 1, 3'd6, 1, 0, 0); checkOutput("nand_keep_c");
    // Stall for three cycles with flush and valid asserted: everything frozen
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 3'b000, 16'h5555, 0, 0, 1, 3'd7, 1, 1, 1); checkOutput("stall");
    end
    // Release stall while flushing: bubble
    applyStimulus(0, 1, 3'b000, 16'h6666, 0, 0, 1, 3'd7, 1, 0, 1); checkOutput("flush_bubble");
    // Plain bubble from ex_valid=0
    applyStimulus(0, 0, 3'b000, 16'h7777, 1, 1, 1, 3'd1, 1, 0, 0); checkOutput("bubble");
    // Back-to-back Z dependency
    applyStimulus(0, 1, 3'b000, 16'h0000, 0, 1, 1, 3'd1, 1, 0, 0); checkOutput("add_z1");
    applyStimulus(0, 1, 3'b010, 16'h0A0A, 0, 0, 0, 3'd2, 1, 0, 0); checkOutput("adz_ok");
    applyStimulus(0, 1, 3'b000, 16'h0001, 0, 0, 1, 3'd1, 1, 0, 0); checkOutput("add_z0");
    applyStimulus(0, 1, 3'b110, 16'h0B0B, 0, 1, 1, 3'd3, 1, 0, 0); checkOutput("ndz_sq");

    // Five consecutive squashes from a clean counter
    applyStimulus(1, 0, 3'b000, 16'h0000, 0, 0, 0, 3'd0, 0, 0, 0); checkOutput("reset2");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 3'b101, 16'h1000 + 16'(i), 1, 1, 1, 3'd5, 1, 0, 0); checkOutput("sat_seq");
    end
    // Reset during a stall loses the held instruction
    applyStimulus(0, 1, 3'b001, 16'h2222, 1, 1, 1, 3'd6, 1, 1, 0); checkOutput("pre_rst_stall");
    applyStimulus(1, 1, 3'b001, 16'h3333, 1, 1, 1, 3'd6, 1, 1, 0); checkOutput("rst_in_stall");

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      applyStimulus(0, 1'($urandom_range(0, 3) != 0), 3'($urandom), 16'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                    1'($urandom), 1'($urandom_range(0, 4) == 0),
                    1'($urandom_range(0, 5) == 0));
      checkOutput("random");
    end

    $display("%0d/%0d checks passed", total_checks - failed_checks, total_checks);
    $finish;
  end

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
